hex_digit_scan: RTL and testbench

Time-multiplexed scanner that drives a 4-digit hex display from one 16-bit value. Sits directly upstream of the hex-to-seven-segment decoder: each digit slot emits the 4-bit nibble for that decoder, plus an active-low digit select and a blank flag. New values arrive over a valid/ready handshake and are double-buffered, so a displayed frame never mixes old and new digits.

---
 rtl/hex_digit_scan.sv | 163 ++++++++++++++++
 tb/tb_hex_digit_scan.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hex_digit_scan.sv
`default_nettype none
// ============================================================================
//  Module   : hex_digit_scan
//  Brief    : Time-multiplexed 4-digit hex display scanner. A 16-bit value is
//             accepted over a valid/ready handshake into a pending buffer and
//             transferred to the display register only at a frame boundary,
//             so a frame never mixes old and new digits. Emits per-digit
//             nibble, active-low one-hot digit select, blank and frame pulse.
//  Options  : HEXSCAN_LZB_EN - when defined, digits above the most
//             significant nonzero nibble are blanked (digit 0 never is).
//  Revision : 1.0 - initial release
// ============================================================================
module hex_digit_scan #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] load_data,
   output logic [3:0]  nibble,
   output logic [3:0]  digit_sel,
   output logic        blank,
   output logic        frame_done
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   localparam logic [19:0] c_div_last = 20'(SCAN_DIV - 1);

   state_t      r_state,     w_state_nxt;
   logic [15:0] r_disp,      w_disp_nxt;
   logic [15:0] r_pend;
   logic        r_pend_full, w_pend_full_nxt;
   logic [1:0]  r_idx,       w_idx_nxt;
   logic [19:0] r_cnt,       w_cnt_nxt;
   logic        r_wrap,      w_wrap_nxt;

   logic [3:0]  r_digit_sel, w_digit_sel_nxt;
   logic [3:0]  r_nibble,    w_nibble_nxt;
   logic        r_blank,     w_blank_nxt;
   logic        r_frame_done;

   logic        w_accept;

   assign w_accept   = load_valid && !r_pend_full;
   assign load_ready = !r_pend_full;
   assign digit_sel  = r_digit_sel;
   assign nibble     = r_nibble;
   assign blank      = r_blank;
   assign frame_done = r_frame_done;

`ifdef HEXSCAN_LZB_EN
   logic [1:0] w_top;

   // Index of the most significant nonzero nibble (0 when the value is zero)
   always_comb begin
      w_top = 2'd0;
      if (r_disp[15:12] != 4'h0)
         w_top = 2'd3;
      else if (r_disp[11:8] != 4'h0)
         w_top = 2'd2;
      else if (r_disp[7:4] != 4'h0)
         w_top = 2'd1;
   end
`endif

   // Next-state, buffer transfer and next output values
   always_comb begin
      w_state_nxt     = r_state;
      w_disp_nxt      = r_disp;
      w_pend_full_nxt = r_pend_full;
      w_idx_nxt       = r_idx;
      w_cnt_nxt       = r_cnt;
      w_wrap_nxt      = 1'b0;
      w_digit_sel_nxt = 4'b1111;
      w_nibble_nxt    = 4'h0;
      w_blank_nxt     = 1'b1;

      // Accept and transfer are mutually exclusive: accept needs an empty buffer
      if (w_accept)
         w_pend_full_nxt = 1'b1;

      case (r_state)
         ST_IDLE: begin
            if (r_pend_full) begin
               w_disp_nxt      = r_pend;
               w_pend_full_nxt = 1'b0;
               w_idx_nxt       = 2'd0;
               w_cnt_nxt       = 20'd0;
               w_state_nxt     = ST_SCAN;
            end
         end
         ST_SCAN: begin
            w_digit_sel_nxt        = 4'b1111;
            w_digit_sel_nxt[r_idx] = 1'b0;
            w_nibble_nxt           = r_disp[{r_idx, 2'b00} +: 4];
`ifdef HEXSCAN_LZB_EN
            w_blank_nxt            = (r_idx > w_top);
`else
            w_blank_nxt            = 1'b0;
`endif
            if (r_cnt == c_div_last) begin
               w_cnt_nxt = 20'd0;
               w_idx_nxt = r_idx + 2'd1;
               if (r_idx == 2'd3) begin
                  // Outputs lag state by one cycle, so the pulse is delayed once more
                  w_wrap_nxt = 1'b1;
                  if (r_pend_full) begin
                     w_disp_nxt      = r_pend;
                     w_pend_full_nxt = 1'b0;
                  end
               end
            end else begin
               w_cnt_nxt = r_cnt + 20'd1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any pending value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_disp      <= 16'h0000;
         r_pend      <= 16'h0000;
         r_pend_full <= 1'b0;
         r_idx       <= 2'd0;
         r_cnt       <= 20'd0;
         r_wrap      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_disp      <= w_disp_nxt;
         r_pend_full <= w_pend_full_nxt;
         r_idx       <= w_idx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_wrap      <= w_wrap_nxt;
         if (w_accept)
            r_pend <= load_data;
      end
   end

   // Registered outputs; asynchronous reset forces idle values at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_digit_sel  <= 4'b1111;
         r_nibble     <= 4'h0;
         r_blank      <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_digit_sel  <= w_digit_sel_nxt;
         r_nibble     <= w_nibble_nxt;
         r_blank      <= w_blank_nxt;
         r_frame_done <= r_wrap;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hex_digit_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_digit_scan
//  Brief    : Scoreboard bench for hex_digit_scan with SCAN_DIV=4. Stimulus
//             pushes the expected per-cycle output record; a monitor pops and
//             compares on every falling edge. Build with HEXSCAN_LZB_EN to
//             check the leading-zero-blanking variant.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_digit_scan;

   localparam int unsigned c_div = 4;

`ifdef HEXSCAN_LZB_EN
   localparam logic c_lzb = 1'b1;
`else
   localparam logic c_lzb = 1'b0;
`endif

   // {digit_sel, nibble, blank, frame_done, load_ready}
   typedef logic [10:0] exp_t;

   localparam exp_t c_idle_rdy = {4'b1111, 4'h0, 1'b1, 1'b0, 1'b1};
   localparam exp_t c_idle_bsy = {4'b1111, 4'h0, 1'b1, 1'b0, 1'b0};

   logic        clk;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic [3:0]  nibble;
   logic [3:0]  digit_sel;
   logic        blank;
   logic        frame_done;

   exp_t exp_q[$];
   int   tag_q[$];
   bit   mon_on;
   int   n_tests;
   int   n_fail;

   hex_digit_scan #(.SCAN_DIV(c_div)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .nibble     (nibble),
      .digit_sel  (digit_sel),
      .blank      (blank),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point shared by monitor and direct checks
   task automatic chk(input int tag, input exp_t got, input exp_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL tag%0d sel/nib/blank/fd/rdy got=%b_%h_%b_%b_%b want=%b_%h_%b_%b_%b",
                  tag, got[10:7], got[6:3], got[2], got[1], got[0],
                  exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Monitor: compare DUT outputs against the scoreboard every falling edge
   always @(negedge clk) begin
      if (mon_on) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard underflow at %0t", $time);
         end else begin
            chk(tag_q.pop_front(), {digit_sel, nibble, blank, frame_done, load_ready},
                exp_q.pop_front());
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // Advance one cycle and queue the expected outputs for it
   task automatic cyc(input exp_t e, input int tag);
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Offer v while idle: accept edge, transfer edge, then scanning starts
   task automatic load_idle(input logic [15:0] v, input int tag);
      load_valid = 1'b1;
      load_data  = v;
      cyc(c_idle_bsy, tag);
      load_valid = 1'b0;
      cyc(c_idle_rdy, tag);
   endtask

   // One scan frame of v (ncyc cycles); optional load offered after cycle lc
   task automatic frame(input logic [15:0] v, input logic [3:0] blm, input logic fd0,
                        input int lc, input logic [15:0] ld, input bit hold,
                        input int ncyc, input int tag);
      int         d;
      logic [3:0] sel;
      logic       rdy;
      logic       fd;
      for (int i = 0; i < ncyc; i++) begin
         d      = i / int'(c_div);
         sel    = 4'b1111;
         sel[d] = 1'b0;
         rdy    = !(lc >= 0 && i > lc && i < 15);
         fd     = (i == 0) ? fd0 : 1'b0;
         cyc({sel, v[d*4 +: 4], blm[d], fd, rdy}, tag);
         if (i == lc) begin
            load_valid = 1'b1;
            load_data  = ld;
         end else if (lc >= 0 && i == lc + 1) begin
            if (hold)
               load_data = 16'hFFFF;
            else
               load_valid = 1'b0;
         end
         if (i == 13)
            load_valid = 1'b0;
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      mon_on     = 1'b1;
      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = 16'h0000;

      // Reset held, then released with no load: stays idle
      for (int i = 0; i < 3; i++) cyc(c_idle_rdy, 1);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) cyc(c_idle_rdy, 2);

      // Load A5C3 from idle, two full frames; 1234 offered mid second frame
      // with FFFF held on load_valid while the buffer is full
      load_idle(16'hA5C3, 3);
      frame(16'hA5C3, 4'b0000, 1'b0, -1, 16'h0000, 1'b0, 16, 4);
      frame(16'hA5C3, 4'b0000, 1'b1,  5, 16'h1234, 1'b1, 16, 5);
      frame(16'h1234, 4'b0000, 1'b1,  2, 16'h0040, 1'b0, 16, 6);

      // Leading-zero cases
      frame(16'h0040, c_lzb ? 4'b1100 : 4'b0000, 1'b1, 2, 16'h0000, 1'b0, 16, 7);
      frame(16'h0000, c_lzb ? 4'b1110 : 4'b0000, 1'b1, -1, 16'h0000, 1'b0, 16, 8);

      // Mid digit-2 dwell with a value pending, then asynchronous reset
      frame(16'h0000, c_lzb ? 4'b1110 : 4'b0000, 1'b1, 4, 16'h1234, 1'b0, 10, 9);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #2;
      chk(10, {digit_sel, nibble, blank, frame_done, load_ready}, c_idle_rdy);
      for (int i = 0; i < 2; i++) cyc(c_idle_rdy, 11);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) cyc(c_idle_rdy, 12);

      // Fresh load after reset resumes scanning
      load_idle(16'hBEEF, 13);
      frame(16'hBEEF, 4'b0000, 1'b0, -1, 16'h0000, 1'b0, 8, 14);

      @(negedge clk);
      #1;
      mon_on = 1'b0;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard leftover entries=%0d want=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
